// File: rtl/spi_slave_rx.sv
// SPI receive endpoint: synchronises cs/sclk/mosi into clk, deserialises WIDTH-bit
// frames into rx_data with a one-cycle rx_valid, and shifts tx_data back on miso.
module spi_slave_rx #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned MSB_FIRST   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             spi_cs_l,
    input  logic             sclk,
    input  logic             mosi,
    input  logic [WIDTH-1:0] tx_data,
    output logic             miso,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int unsigned CW        = $clog2(WIDTH + 1);
    localparam logic        IDLE_SCLK = 1'(CPOL);

    localparam logic [1:0] WAIT_HI = 2'd0;
    localparam logic [1:0] IDLE    = 2'd1;
    localparam logic [1:0] SHIFT   = 2'd2;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync, prime_sr;
    logic                   cs_d, sclk_d;
    logic                   cs_s, sclk_s, mosi_s;
    logic                   cs_fall, cs_rise, lead_edge, trail_edge;
    logic                   sample_edge, shift_edge;

    logic [1:0]       state, state_n;
    logic [CW-1:0]    bit_cnt, bit_cnt_n;
    logic [WIDTH-1:0] rx_sr, rx_sr_n, rx_shift;
    logic [WIDTH-1:0] tx_sr, tx_sr_n;
    logic [WIDTH-1:0] rx_data_n;
    logic             skip, skip_n;
    logic             rx_valid_n, frame_err_n, miso_n;
    logic             final_sample;

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign cs_fall     = cs_d && !cs_s;
    assign cs_rise     = !cs_d && cs_s;
    assign lead_edge   = (sclk_d == IDLE_SCLK) && (sclk_s != IDLE_SCLK);
    assign trail_edge  = (sclk_d != IDLE_SCLK) && (sclk_s == IDLE_SCLK);
    assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
    assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;

    // Synchronisers, edge-detect history and a primer that marks when the
    // cs synchroniser holds real samples rather than its reset value.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cs_sync   <= '1;
            sclk_sync <= {SYNC_STAGES{IDLE_SCLK}};
            mosi_sync <= '0;
            prime_sr  <= '0;
            cs_d      <= 1'b1;
            sclk_d    <= IDLE_SCLK;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_l};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            prime_sr  <= {prime_sr[SYNC_STAGES-2:0], 1'b1};
            cs_d      <= cs_s;
            sclk_d    <= sclk_s;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state     <= WAIT_HI;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            skip      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            miso      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            rx_sr     <= rx_sr_n;
            tx_sr     <= tx_sr_n;
            skip      <= skip_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            frame_err <= frame_err_n;
            miso      <= miso_n;
            busy      <= (state_n == SHIFT);
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        rx_sr_n     = rx_sr;
        tx_sr_n     = tx_sr;
        skip_n      = skip;
        rx_data_n   = rx_data;
        rx_valid_n  = 1'b0;
        frame_err_n = 1'b0;
        miso_n      = 1'b0;
        rx_shift    = (MSB_FIRST != 0) ? {rx_sr[WIDTH-2:0], mosi_s}
                                       : {mosi_s, rx_sr[WIDTH-1:1]};
        final_sample = sample_edge && (bit_cnt == CW'(WIDTH - 1));

        case (state)
            WAIT_HI: begin
                if (prime_sr[SYNC_STAGES-1] && cs_s) state_n = IDLE;
            end
            IDLE: begin
                if (cs_fall) begin
                    tx_sr_n   = tx_data;
                    bit_cnt_n = '0;
                    // With CPHA=1 the first shift edge presents bit 0 instead of advancing.
                    skip_n    = (CPHA != 0);
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (sample_edge) begin
                    rx_sr_n = rx_shift;
                    if (final_sample) begin
                        rx_data_n  = rx_shift;
                        rx_valid_n = 1'b1;
                        bit_cnt_n  = '0;
                        tx_sr_n    = tx_data;
                        skip_n     = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + CW'(1);
                    end
                end else if (shift_edge) begin
                    if (skip) begin
                        skip_n = 1'b0;
                    end else begin
                        tx_sr_n = (MSB_FIRST != 0) ? {tx_sr[WIDTH-2:0], 1'b0}
                                                   : {1'b0, tx_sr[WIDTH-1:1]};
                    end
                end
                if (cs_rise) begin
                    state_n     = IDLE;
                    frame_err_n = (bit_cnt != '0) && !final_sample;
                    bit_cnt_n   = '0;
                end
            end
            default: state_n = WAIT_HI;
        endcase

        if (state_n == SHIFT) miso_n = (MSB_FIRST != 0) ? tx_sr_n[WIDTH-1] : tx_sr_n[0];
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: five instances covering the four SPI modes
// and LSB-first ordering, driven by a shared behavioural SPI master.
module tb_spi_slave_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_l, spi_cs_l, sclk, mosi;
    logic [15:0] tx_data;
    logic [4:0]  miso, rx_valid, frame_err, busy;
    logic [15:0] rx_data [5];

    int errors = 0;
    int checks = 0;
    int vcnt [5];
    int ecnt [5];
    int both [5];
    logic [15:0] vlog [$];

    spi_slave_rx #(.WIDTH(16), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m0 (
        .clk(clk), .reset_l(reset_l), .spi_cs_l(spi_cs_l), .sclk(sclk), .mosi(mosi),
        .tx_data(tx_data), .miso(miso[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .frame_err(frame_err[0]), .busy(busy[0]));
    spi_slave_rx #(.WIDTH(16), .CPOL(0), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m1 (
        .clk(clk), .reset_l(reset_l), .spi_cs_l(spi_cs_l), .sclk(sclk), .mosi(mosi),
        .tx_data(tx_data), .miso(miso[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .frame_err(frame_err[1]), .busy(busy[1]));
    spi_slave_rx #(.WIDTH(16), .CPOL(1), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m2 (
        .clk(clk), .reset_l(reset_l), .spi_cs_l(spi_cs_l), .sclk(sclk), .mosi(mosi),
        .tx_data(tx_data), .miso(miso[2]), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]),
        .frame_err(frame_err[2]), .busy(busy[2]));
    spi_slave_rx #(.WIDTH(16), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m3 (
        .clk(clk), .reset_l(reset_l), .spi_cs_l(spi_cs_l), .sclk(sclk), .mosi(mosi),
        .tx_data(tx_data), .miso(miso[3]), .rx_data(rx_data[3]), .rx_valid(rx_valid[3]),
        .frame_err(frame_err[3]), .busy(busy[3]));
    spi_slave_rx #(.WIDTH(16), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2)) u_lsb (
        .clk(clk), .reset_l(reset_l), .spi_cs_l(spi_cs_l), .sclk(sclk), .mosi(mosi),
        .tx_data(tx_data), .miso(miso[4]), .rx_data(rx_data[4]), .rx_valid(rx_valid[4]),
        .frame_err(frame_err[4]), .busy(busy[4]));

    // Pulse counters and a log of words delivered by the mode-0 instance.
    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (rx_valid[i] === 1'b1) vcnt[i]++;
            if (frame_err[i] === 1'b1) ecnt[i]++;
            if (rx_valid[i] === 1'b1 && frame_err[i] === 1'b1) both[i]++;
        end
        if (rx_valid[0] === 1'b1) vlog.push_back(rx_data[0]);
    end

    task automatic half_period();
        repeat (5) @(negedge clk);
    endtask

    task automatic cs_low();
        spi_cs_l = 1'b0;
        half_period();
    endtask

    task automatic cs_high();
        half_period();
        spi_cs_l = 1'b1;
        half_period();
        half_period();
    endtask

    // Master shifts nbits of word; cap collects miso at the master's sample edges.
    task automatic shift_word(input int cpol, input int cpha, input bit lsb,
                              input logic [15:0] word, input int nbits, input int inst,
                              output logic [15:0] cap);
        cap = '0;
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = lsb ? i : 15 - i;
            if (cpha == 0) begin
                mosi = word[b];
                half_period();
                sclk = (cpol == 0);
                cap[b] = miso[inst];
                half_period();
                sclk = (cpol != 0);
            end else begin
                sclk = (cpol == 0);
                mosi = word[b];
                half_period();
                sclk = (cpol != 0);
                cap[b] = miso[inst];
                half_period();
            end
        end
    endtask

    task automatic test_reset();
        reset_l  = 1'b0;
        spi_cs_l = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        tx_data  = 16'h3C5A;
        repeat (3) @(negedge clk);
        checks++; if (rx_data[0] !== 16'h0000) begin errors++; $display("FAIL reset_rx_data got=%h exp=0000", rx_data[0]); end
        checks++; if (rx_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid[0]); end
        checks++; if (frame_err[0] !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err[0]); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy[0]); end
        checks++; if (miso[0] !== 1'b0) begin errors++; $display("FAIL reset_miso got=%b exp=0", miso[0]); end
        reset_l = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_single();
        logic [15:0] cap;
        int v0, e0;
        v0 = vcnt[0]; e0 = ecnt[0];
        tx_data = 16'h3C5A;
        checks++; if (miso[0] !== 1'b0) begin errors++; $display("FAIL miso_before_cs got=%b exp=0", miso[0]); end
        cs_low();
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL busy_in_frame got=%b exp=1", busy[0]); end
        shift_word(0, 0, 1'b0, 16'hA569, 16, 0, cap);
        cs_high();
        checks++; if (vcnt[0] - v0 !== 1) begin errors++; $display("FAIL single_valid_count got=%0d exp=1", vcnt[0] - v0); end
        checks++; if (rx_data[0] !== 16'hA569) begin errors++; $display("FAIL single_rx_data got=%h exp=a569", rx_data[0]); end
        checks++; if (ecnt[0] - e0 !== 0) begin errors++; $display("FAIL single_frame_err got=%0d exp=0", ecnt[0] - e0); end
        checks++; if (cap !== 16'h3C5A) begin errors++; $display("FAIL single_miso_word got=%h exp=3c5a", cap); end
        checks++; if (miso[0] !== 1'b0) begin errors++; $display("FAIL miso_after_cs got=%b exp=0", miso[0]); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL busy_after_cs got=%b exp=0", busy[0]); end
    endtask

    task automatic test_frame_err();
        logic [15:0] cap;
        int v0, e0;
        v0 = vcnt[0]; e0 = ecnt[0];
        cs_low();
        shift_word(0, 0, 1'b0, 16'hFFFF, 7, 0, cap);
        cs_high();
        checks++; if (ecnt[0] - e0 !== 1) begin errors++; $display("FAIL ferr_count got=%0d exp=1", ecnt[0] - e0); end
        checks++; if (vcnt[0] - v0 !== 0) begin errors++; $display("FAIL ferr_valid_count got=%0d exp=0", vcnt[0] - v0); end
        checks++; if (rx_data[0] !== 16'hA569) begin errors++; $display("FAIL ferr_rx_data got=%h exp=a569", rx_data[0]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] cap;
        int v0, e0, n0;
        v0 = vcnt[0]; e0 = ecnt[0]; n0 = vlog.size();
        cs_low();
        shift_word(0, 0, 1'b0, 16'h1234, 16, 0, cap);
        shift_word(0, 0, 1'b0, 16'hBEEF, 16, 0, cap);
        cs_high();
        checks++; if (vcnt[0] - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count got=%0d exp=2", vcnt[0] - v0); end
        checks++; if (ecnt[0] - e0 !== 0) begin errors++; $display("FAIL b2b_frame_err got=%0d exp=0", ecnt[0] - e0); end
        if (vlog.size() >= n0 + 2) begin
            checks++; if (vlog[n0] !== 16'h1234) begin errors++; $display("FAIL b2b_word0 got=%h exp=1234", vlog[n0]); end
            checks++; if (vlog[n0+1] !== 16'hBEEF) begin errors++; $display("FAIL b2b_word1 got=%h exp=beef", vlog[n0+1]); end
        end else begin
            checks++; errors++;
            $display("FAIL b2b_words got=%0d words exp=2", vlog.size() - n0);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] cap;
        int v0, e0;
        cs_low();
        shift_word(0, 0, 1'b0, 16'h5555, 5, 0, cap);
        reset_l = 1'b0;
        #1;
        checks++; if (rx_data[0] !== 16'h0000) begin errors++; $display("FAIL midrst_rx_data got=%h exp=0000", rx_data[0]); end
        checks++; if ({rx_valid[0], frame_err[0], busy[0], miso[0]} !== 4'b0000) begin
            errors++; $display("FAIL midrst_flags got=%b exp=0000", {rx_valid[0], frame_err[0], busy[0], miso[0]});
        end
        repeat (3) @(negedge clk);
        reset_l = 1'b1;
        v0 = vcnt[0]; e0 = ecnt[0];
        shift_word(0, 0, 1'b0, 16'h5555, 11, 0, cap);
        shift_word(0, 0, 1'b0, 16'h1234, 16, 0, cap);
        checks++; if (vcnt[0] - v0 !== 0) begin errors++; $display("FAIL midrst_no_valid got=%0d exp=0", vcnt[0] - v0); end
        cs_high();
        checks++; if (ecnt[0] - e0 !== 0) begin errors++; $display("FAIL midrst_frame_err got=%0d exp=0", ecnt[0] - e0); end
        v0 = vcnt[0];
        cs_low();
        shift_word(0, 0, 1'b0, 16'h0F0F, 16, 0, cap);
        cs_high();
        checks++; if (vcnt[0] - v0 !== 1) begin errors++; $display("FAIL midrst_next_valid got=%0d exp=1", vcnt[0] - v0); end
        checks++; if (rx_data[0] !== 16'h0F0F) begin errors++; $display("FAIL midrst_next_data got=%h exp=0f0f", rx_data[0]); end
    endtask

    task automatic test_modes();
        logic [15:0] cap;
        int v0;
        tx_data = 16'h3C5A;
        for (int m = 0; m < 5; m++) begin
            int cpol, cpha;
            bit lsb;
            cpol = (m < 4) ? m / 2 : 0;
            cpha = (m < 4) ? m % 2 : 0;
            lsb  = (m == 4);
            sclk = (cpol != 0);
            repeat (4) half_period();
            v0 = vcnt[m];
            cs_low();
            shift_word(cpol, cpha, lsb, 16'h8001, 16, m, cap);
            cs_high();
            checks++; if (rx_data[m] !== 16'h8001) begin errors++; $display("FAIL mode%0d_rx_data got=%h exp=8001", m, rx_data[m]); end
            checks++; if (vcnt[m] - v0 !== 1) begin errors++; $display("FAIL mode%0d_valid_count got=%0d exp=1", m, vcnt[m] - v0); end
            checks++; if (cap !== 16'h3C5A) begin errors++; $display("FAIL mode%0d_miso_word got=%h exp=3c5a", m, cap); end
        end
        checks++; if (both[0] !== 0) begin errors++; $display("FAIL valid_and_ferr_together got=%0d exp=0", both[0]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_modes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
